// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - M-stage load/store unit driving a req/gnt/rvalid data bus
// Lane steering, load extension, misalign rejection and bus timeout; stalls the pipeline per access.
module dmem_lsu #(
  parameter int XLEN     = 32,
  parameter int TO_W     = 8,
  parameter int TO_LIMIT = 200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ReqValidM,
  input  logic              MemWriteM,
  input  logic [2:0]        LSTypeM,
  input  logic [XLEN-1:0]   ALUResultM,
  input  logic [XLEN-1:0]   WriteDataM,
  output logic [XLEN-1:0]   ReadDataM,
  output logic              DoneM,
  output logic              StallM,
  output logic              MisalignM,
  output logic              TimeoutM,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_be,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam int NB  = XLEN / 8;
  localparam int OFF = $clog2(NB);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic [NB-1:0]     be_q, be_d;
  logic              we_q, we_d;
  logic [2:0]        type_q, type_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;

  logic              legal;
  logic              misal;
  logic              bad;
  logic              launch;
  logic [OFF-1:0]    off_in;
  logic [NB-1:0]     be_base;
  logic [NB-1:0]     be_in;
  logic [XLEN-1:0]   wdata_in;
  logic              timeout;
  logic              capture;
  logic [XLEN-1:0]   ld_shift;
  logic [XLEN-1:0]   ld_keep;
  logic              ld_sbit;
  logic [XLEN-1:0]   ld_ext;

  // Request decode; illegal widths for this XLEN are rejected like misaligned ones.
  always_comb begin
    legal = 1'b1;
    misal = 1'b0;
    case (LSTypeM)
      3'b000, 3'b100: misal = 1'b0;
      3'b001, 3'b101: misal = ALUResultM[0];
      3'b010:         misal = |ALUResultM[1:0];
      3'b110: begin
        legal = (XLEN == 64);
        misal = |ALUResultM[1:0];
      end
      3'b011: begin
        legal = (XLEN == 64);
        misal = |ALUResultM[2:0];
      end
      default:        legal = 1'b0;
    endcase
  end

  assign bad    = ~legal | misal;
  assign launch = ReqValidM & ~bad;
  assign off_in = ALUResultM[OFF-1:0];

  always_comb begin
    be_base  = NB'(1);
    wdata_in = {NB{WriteDataM[7:0]}};
    case (LSTypeM[1:0])
      2'b00: begin
        be_base  = NB'(1);
        wdata_in = {NB{WriteDataM[7:0]}};
      end
      2'b01: begin
        be_base  = NB'(3);
        wdata_in = {(NB/2){WriteDataM[15:0]}};
      end
      2'b10: begin
        be_base  = NB'(4'hF);
        wdata_in = {(NB/4){WriteDataM[31:0]}};
      end
      default: begin
        be_base  = NB'(8'hFF);
        wdata_in = WriteDataM;
      end
    endcase
  end

  assign be_in = be_base << off_in;

  assign timeout = ((state_q == REQ) || (state_q == WAIT)) && (cnt_q == TO_W'(TO_LIMIT));
  assign capture = ~we_q & ~timeout & mem_rvalid &
                   (((state_q == REQ) & mem_gnt) | (state_q == WAIT));

  // Load extraction from the captured beat using the latched offset and type.
  always_comb begin
    ld_shift = rdata_q >> {addr_q[OFF-1:0], 3'b000};
    ld_keep  = '1;
    ld_sbit  = 1'b0;
    case (type_q[1:0])
      2'b00: begin
        ld_keep = XLEN'(8'hFF);
        ld_sbit = ld_shift[7];
      end
      2'b01: begin
        ld_keep = XLEN'(16'hFFFF);
        ld_sbit = ld_shift[15];
      end
      2'b10: begin
        ld_keep = XLEN'(32'hFFFF_FFFF);
        ld_sbit = ld_shift[31];
      end
      default: begin
        ld_keep = '1;
        ld_sbit = 1'b0;
      end
    endcase
    ld_ext = (ld_shift & ld_keep) | ((~type_q[2] & ld_sbit) ? ~ld_keep : '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (launch) state_d = REQ;
      end
      REQ: begin
        if (timeout)                           state_d = DONE;
        else if (mem_gnt && (we_q || capture)) state_d = DONE;
        else if (mem_gnt)                      state_d = WAIT;
      end
      WAIT: begin
        if (timeout || capture) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    StallM    = 1'b0;
    DoneM     = 1'b0;
    MisalignM = 1'b0;
    TimeoutM  = 1'b0;
    mem_req   = 1'b0;
    case (state_q)
      IDLE: begin
        StallM    = launch;
        MisalignM = ReqValidM & bad;
      end
      REQ: begin
        StallM   = 1'b1;
        mem_req  = ~timeout;
        TimeoutM = timeout;
      end
      WAIT: begin
        StallM   = 1'b1;
        TimeoutM = timeout;
      end
      default: DoneM = 1'b1;
    endcase
    mem_we    = mem_req & we_q;
    mem_addr  = mem_req ? {addr_q[XLEN-1:OFF], {OFF{1'b0}}} : '0;
    mem_wdata = mem_req ? wdata_q : '0;
    mem_be    = mem_req ? be_q : '0;
    ReadDataM = (DoneM && !we_q) ? ld_ext : '0;
  end

  // Access context is frozen at launch; counter and capture only move while the bus is owned.
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    be_d    = be_q;
    we_d    = we_q;
    type_d  = type_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (launch) begin
          addr_d  = ALUResultM;
          wdata_d = wdata_in;
          be_d    = be_in;
          we_d    = MemWriteM;
          type_d  = LSTypeM;
          rdata_d = '0;
          cnt_d   = '0;
        end
      end
      REQ, WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (timeout)      rdata_d = '0;
        else if (capture) rdata_d = mem_rdata;
      end
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      type_q  <= '0;
      cnt_q   <= '0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      be_q    <= be_d;
      we_q    <= we_d;
      type_q  <= type_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// tb/tb_dmem_lsu.sv - randomized bench for dmem_lsu against a behavioural access model
module tb_dmem_lsu;

  localparam int XLEN     = 32;
  localparam int TO_W     = 8;
  localparam int TO_LIMIT = 200;

  logic        clk;
  logic        rst;
  logic        ReqValidM;
  logic        MemWriteM;
  logic [2:0]  LSTypeM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;
  logic        DoneM;
  logic        StallM;
  logic        MisalignM;
  logic        TimeoutM;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  dmem_lsu #(.XLEN(XLEN), .TO_W(TO_W), .TO_LIMIT(TO_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .ReqValidM(ReqValidM), .MemWriteM(MemWriteM), .LSTypeM(LSTypeM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .ReadDataM(ReadDataM),
    .DoneM(DoneM), .StallM(StallM), .MisalignM(MisalignM), .TimeoutM(TimeoutM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One M-stage access. gd = REQ cycles before gnt, rd = cycles from gnt to rvalid (0 = same cycle).
  task automatic run_access(input logic we, input logic [2:0] t, input logic [31:0] a,
                            input logic [31:0] wd, input int gd, input int rd,
                            input logic [31:0] rdat);
    int sz, szr, idx, exp_stall, exp_req;
    logic mis, exp_to;
    logic [31:0] exp_be, exp_wd, exp_rd, mask, v;
    int stalls, mis_n, to_n, done_n, req_n, badreq, gnt_c;
    logic [31:0] rd_got;
    logic fin;

    case (t)
      3'd0, 3'd4: sz = 1;
      3'd1, 3'd5: sz = 2;
      3'd2:       sz = 4;
      default:    sz = 0;
    endcase
    szr = (sz == 0) ? 1 : sz;
    mis = (sz == 0) ? 1'b1 : ((a % sz) != 0);
    idx = we ? gd : gd + rd;
    exp_to = (idx >= TO_LIMIT);
    exp_stall = mis ? 0 : 2 + (exp_to ? TO_LIMIT : idx);
    exp_req = mis ? 0 : ((gd < TO_LIMIT) ? gd + 1 : TO_LIMIT);
    exp_be = ((32'd1 << sz) - 32'd1) << (a % 4);
    exp_wd = '0;
    for (int i = 0; i < 4; i++) exp_wd |= ((wd >> (8 * (i % szr))) & 32'hFF) << (8 * i);
    mask = (szr == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * szr)) - 32'd1);
    v = (rdat >> (8 * (a % 4))) & mask;
    if (!t[2] && (((v >> (8 * szr - 1)) & 32'd1) != 0)) v |= ~mask;
    exp_rd = (we || exp_to) ? 32'd0 : v;

    stalls = 0; mis_n = 0; to_n = 0; done_n = 0; req_n = 0; badreq = 0; gnt_c = -1;
    rd_got = '0; fin = 1'b0;

    @(negedge clk);
    ReqValidM = 1'b1; MemWriteM = we; LSTypeM = t; ALUResultM = a; WriteDataM = wd;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
    for (int c = 0; c < TO_LIMIT + 20 && !fin; c++) begin
      #1;
      if (StallM) stalls++;
      if (MisalignM) mis_n++;
      if (TimeoutM) to_n++;
      if (DoneM) begin
        done_n++;
        rd_got = ReadDataM;
        fin = 1'b1;
      end
      if (mem_req) begin
        if (mem_addr !== (a & ~32'h3) || mem_be !== exp_be[3:0] ||
            mem_wdata !== exp_wd || mem_we !== we) badreq++;
        if (req_n == gd) begin
          mem_gnt = 1'b1;
          gnt_c = c;
        end
        req_n++;
      end
      if (!we && gnt_c >= 0 && c == gnt_c + rd) begin
        mem_rvalid = 1'b1;
        mem_rdata = rdat;
      end
      if (mis && c == 0) fin = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
      ReqValidM = 1'($urandom_range(0, 1));
      MemWriteM = 1'($urandom_range(0, 1));
      LSTypeM = 3'($urandom_range(0, 7));
      ALUResultM = $urandom; WriteDataM = $urandom;
    end
    ReqValidM = 1'b0;

    check_val("stall_cycles", 64'(stalls), 64'(exp_stall));
    check_val("misalign_pulse", 64'(mis_n), 64'(mis));
    check_val("timeout_pulse", 64'(to_n), 64'(exp_to && !mis));
    check_val("done_pulse", 64'(done_n), 64'(!mis));
    check_val("req_cycles", 64'(req_n), 64'(exp_req));
    check_val("bus_fields", 64'(badreq), 64'(0));
    if (!mis) check_val("read_data", 64'(rd_got), 64'(exp_rd));
    #1;
    check_val("idle_after", 64'({StallM, mem_req, DoneM}), 64'(0));
  endtask

  logic        r_we;
  logic [2:0]  r_t;
  logic [31:0] r_a;

  initial begin
    rst = 1'b1;
    ReqValidM = 1'b0; MemWriteM = 1'b0; LSTypeM = '0; ALUResultM = '0; WriteDataM = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    #1;
    check_val("rst_ctl", 64'({StallM, DoneM, MisalignM, TimeoutM, mem_req, mem_we, mem_be}), 64'(0));
    check_val("rst_rdata", 64'(ReadDataM), 64'(0));
    check_val("rst_bus", 64'(mem_addr | mem_wdata), 64'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_access(1'b0, 3'b010, 32'h100, 32'h0,        0, 2, 32'hDEADBEEF);
    run_access(1'b1, 3'b000, 32'h103, 32'h000000A5, 0, 0, 32'h0);
    run_access(1'b0, 3'b000, 32'h102, 32'h0,        0, 0, 32'h0080FF00);
    run_access(1'b0, 3'b101, 32'h102, 32'h0,        1, 1, 32'h80010000);
    run_access(1'b0, 3'b010, 32'h102, 32'h0,        0, 0, 32'h12345678);
    run_access(1'b1, 3'b001, 32'h101, 32'h1234,     0, 0, 32'h0);
    run_access(1'b0, 3'b111, 32'h100, 32'h0,        0, 0, 32'h0);
    run_access(1'b1, 3'b011, 32'h108, 32'h0,        0, 0, 32'h0);
    run_access(1'b0, 3'b010, 32'h100, 32'h0,        1000, 0, 32'hCAFEF00D);
    run_access(1'b0, 3'b001, 32'h202, 32'h0,        0, 1000, 32'hCAFEF00D);
    run_access(1'b1, 3'b010, 32'h204, 32'h89ABCDEF, 3, 0, 32'h0);

    for (int k = 0; k < 80; k++) begin
      r_we = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 11))
        0, 1:    r_t = 3'b000;
        2, 3:    r_t = 3'b001;
        4, 5:    r_t = 3'b010;
        6, 7:    r_t = 3'b100;
        8, 9:    r_t = 3'b101;
        10:      r_t = 3'b110;
        default: r_t = 3'b111;
      endcase
      r_a = 32'h2000 + $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) r_a = r_a & ~32'h3;
      run_access(r_we, r_t, r_a, $urandom, int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), $urandom);
    end

    @(negedge clk);
    ReqValidM = 1'b1; MemWriteM = 1'b0; LSTypeM = 3'b010; ALUResultM = 32'h100;
    @(negedge clk);
    ReqValidM = 1'b0;
    #1;
    check_val("rst_pre_req", 64'(mem_req), 64'(1));
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    #1;
    check_val("rst_pre_wait", 64'({StallM, mem_req}), 64'(2'b10));
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("rst_async", 64'({mem_req, StallM, DoneM}), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h55AA55AA;
    #1;
    check_val("stray_rvalid", 64'({DoneM, StallM, mem_req}), 64'(0));
    @(negedge clk);
    mem_rvalid = 1'b0;
    #1;
    check_val("stray_after", 64'({DoneM, StallM, mem_req}), 64'(0));
    run_access(1'b0, 3'b010, 32'h300, 32'h0, 0, 1, 32'h0BADC0DE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
